// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the mem_arbiter slice.
//   arb_state_e    - arbiter sequencer states, one per memory command plus RESP
//   ARB_STARVE_MAX - data grants tolerated while a fetch waits (fair build)
//   STARVE_CW      - width of the starvation counter
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DATA     = 3'd1,
    FETCH_HI = 3'd2,
    FETCH_LO = 3'd3,
    RESP     = 3'd4
  } arb_state_e;

  localparam int ARB_STARVE_MAX = 4;
  localparam int STARVE_CW      = 3;

endpackage

// File: rtl/mem_arb_starve.sv
// mem_arb_starve: saturating count of data grants issued while a fetch waits.
// Only instantiated when MEM_ARB_FAIR_EN is defined.
// Ports:
//   clk, rst      - clock, async active-low reset
//   dm_grant_i    - data grant issued this cycle (IDLE only)
//   if_pend_i     - fetch request pending
//   if_grant_i    - fetch grant issued this cycle; clears the count
//   starve_o      - count has reached ARB_STARVE_MAX; next grant goes to fetch
module mem_arb_starve
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic dm_grant_i,
  input  logic if_pend_i,
  input  logic if_grant_i,
  output logic starve_o
);

  localparam logic [STARVE_CW-1:0] CNT_MAX = STARVE_CW'(ARB_STARVE_MAX);

  logic [STARVE_CW-1:0] cnt_q;
  logic [STARVE_CW-1:0] cnt_d;

  // Next count: clear on fetch grant, saturate at CNT_MAX otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (if_grant_i) begin
      cnt_d = {STARVE_CW{1'b0}};
    end else if (dm_grant_i && if_pend_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(STARVE_CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {STARVE_CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 16-bit memory between instruction fetch
// (two word reads per 32-bit instruction) and the data stage (one access).
// Optional feature: define MEM_ARB_FAIR_EN to bound fetch starvation; without
// it data has strict priority.
// Ports:
//   clk, rst                      - clock, async active-low reset
//   if_req/if_addr/if_flush       - fetch request, high-half address, jump flush
//   if_ack/if_instr               - fetch completion pulse and instruction
//   dm_req/dm_wr/dm_addr/dm_wdata - data request and command
//   dm_ack/dm_rdata               - data completion pulse and read data
//   stall_if/stall_dm             - req & ~ack per port (combinational)
//   mem_req/mem_wr/mem_addr/mem_wdata - memory command, held until mem_ack
//   mem_ack/mem_rdata             - memory completion pulse and read data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  input  logic          if_flush,
  output logic          if_ack,
  output logic [31:0]   if_instr,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [15:0]   dm_addr,
  input  logic [15:0]   dm_wdata,
  output logic          dm_ack,
  output logic [15:0]   dm_rdata,
  output logic          stall_if,
  output logic          stall_dm,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata
);

  arb_state_e    state_q;
  logic          kill_q;
  logic          resp_if_q;
  logic          dm_ack_q;
  logic [31:0]   if_instr_q;
  logic [15:0]   dm_rdata_q;
  logic          mem_req_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [15:0]   mem_wdata_q;

  logic fetch_ok_s;
  logic grant_if_s;
  logic grant_dm_s;
  logic unused_if_addr_s;

  // Only the low AW bits of the fetch address reach the memory.
  assign unused_if_addr_s = &{1'b0, if_addr};

  assign fetch_ok_s = if_req & ~if_flush;

`ifdef MEM_ARB_FAIR_EN
  logic starve_s;

  mem_arb_starve u_starve (
    .clk        (clk),
    .rst        (rst),
    .dm_grant_i (grant_dm_s),
    .if_pend_i  (if_req),
    .if_grant_i (grant_if_s),
    .starve_o   (starve_s)
  );

  // Fetch wins in IDLE when data is absent or the fetch has starved.
  assign grant_if_s = (state_q == IDLE) & fetch_ok_s & (~dm_req | starve_s);
`else
  // Strict data priority.
  assign grant_if_s = (state_q == IDLE) & fetch_ok_s & ~dm_req;
`endif

  assign grant_dm_s = (state_q == IDLE) & dm_req & ~grant_if_s;

  // Sequencer: one state per memory command, RESP drives the acks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      resp_if_q   <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_instr_q  <= 32'h0000_0000;
      dm_rdata_q  <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          kill_q    <= 1'b0;
          resp_if_q <= 1'b0;
          dm_ack_q  <= 1'b0;
          if (grant_dm_s) begin
            mem_req_q   <= 1'b1;
            mem_wr_q    <= dm_wr;
            mem_addr_q  <= AW'(dm_addr);
            mem_wdata_q <= dm_wdata;
            state_q     <= DATA;
          end else if (grant_if_s) begin
            mem_req_q  <= 1'b1;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= if_addr[AW-1:0];
            state_q    <= FETCH_HI;
          end else begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_wr_q) begin
              dm_rdata_q <= mem_rdata;
            end else begin
              dm_rdata_q <= dm_rdata_q;
            end
            dm_ack_q <= 1'b1;
            state_q  <= RESP;
          end else begin
            state_q <= DATA;
          end
        end
        FETCH_HI: begin
          kill_q <= kill_q | if_flush;
          if (mem_ack) begin
            // A flushed fetch lets the in-flight read finish, then skips the low half.
            if (kill_q || if_flush) begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              if_instr_q[31:16] <= mem_rdata;
              mem_addr_q        <= mem_addr_q + AW'(1);
              state_q           <= FETCH_LO;
            end
          end else begin
            state_q <= FETCH_HI;
          end
        end
        FETCH_LO: begin
          kill_q <= kill_q | if_flush;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (kill_q || if_flush) begin
              state_q <= IDLE;
            end else begin
              if_instr_q[15:0] <= mem_rdata;
              resp_if_q        <= 1'b1;
              state_q          <= RESP;
            end
          end else begin
            state_q <= FETCH_LO;
          end
        end
        RESP: begin
          resp_if_q <= 1'b0;
          dm_ack_q  <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          resp_if_q <= 1'b0;
          dm_ack_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // A flush arriving in RESP still suppresses the fetch ack.
  assign if_ack    = resp_if_q & ~if_flush & ~kill_q;
  assign dm_ack    = dm_ack_q;
  assign if_instr  = if_instr_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = if_req & ~if_ack;
  assign stall_dm  = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a latency-programmable
// memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_flush = 1'b0;
  logic        if_ack;
  logic [31:0] if_instr;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = 16'h0;
  logic [15:0] dm_wdata = 16'h0;
  logic        dm_ack;
  logic [15:0] dm_rdata;
  logic        stall_if;
  logic        stall_dm;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] mem [0:65535];
  int          lat = 0;
  int          wait_cnt = 0;
  logic [15:0] log_a [0:255];
  int          log_n = 0;
  logic [15:0] last_wr_addr = 16'h0;
  logic [15:0] last_wr_data = 16'h0;

  mem_arbiter #(.AW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_instr(if_instr),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: acks a command after lat cycles of mem_req, logs addresses.
  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (mem_req && !mem_ack) begin
      if (wait_cnt >= lat) begin
        mem_ack         <= 1'b1;
        mem_rdata       <= mem[mem_addr];
        log_a[log_n[7:0]] <= mem_addr;
        log_n           <= log_n + 1;
        if (mem_wr) begin
          last_wr_addr <= mem_addr;
          last_wr_data <= mem_wdata;
        end
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle(3);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_checks++; if (if_ack !== 1'b0 || dm_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks got %b%b exp 00", if_ack, dm_ack); end
    n_checks++; if (if_instr !== 32'h0 || dm_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h %h exp 0 0", if_instr, dm_rdata); end
    n_checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_cmd got %h %h %b exp 0", mem_addr, mem_wdata, mem_wr); end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_data_read;
    int base, mack_i, dack_i;
    base = log_n; mack_i = -1; dack_i = -1; lat = 2;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (mem_ack && mack_i < 0) mack_i = i;
      if (dm_ack) begin dack_i = i; break; end
    end
    dm_req = 1'b0;
    n_checks++; if (mack_i !== 4) begin n_fail++; $display("FAIL rd_mem_ack_cycle got %0d exp 4", mack_i); end
    n_checks++; if (dack_i !== 5) begin n_fail++; $display("FAIL rd_dm_ack_cycle got %0d exp 5", dack_i); end
    n_checks++; if (dm_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data got %h exp beef", dm_rdata); end
    n_checks++; if (log_n - base !== 1 || log_a[base[7:0]] !== 16'h0010) begin n_fail++; $display("FAIL rd_mem_txn got n=%0d a=%h exp 1 0010", log_n - base, log_a[base[7:0]]); end
    idle(2);
  endtask

  task automatic test_data_write;
    int dack_i;
    dack_i = -1; lat = 0;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'hA5A5;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (dm_ack) begin dack_i = i; break; end
    end
    dm_req = 1'b0; dm_wr = 1'b0;
    n_checks++; if (dack_i !== 3) begin n_fail++; $display("FAIL wr_ack_cycle got %0d exp 3", dack_i); end
    n_checks++; if (last_wr_addr !== 16'h0030 || last_wr_data !== 16'hA5A5) begin n_fail++; $display("FAIL wr_mem got %h %h exp 0030 a5a5", last_wr_addr, last_wr_data); end
    n_checks++; if (dm_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rdata_kept got %h exp beef", dm_rdata); end
    idle(2);
  endtask

  task automatic test_fetch(input logic [31:0] addr, input logic [15:0] a0, input logic [15:0] a1, input logic [31:0] exp_instr, input int exp_cyc);
    int base, iack_i;
    base = log_n; iack_i = -1; lat = 0;
    if_req = 1'b1; if_addr = addr;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch_stall got %b exp 1", stall_if); end
      end
      if (if_ack) begin iack_i = i; break; end
    end
    if_req = 1'b0;
    n_checks++; if (iack_i !== exp_cyc) begin n_fail++; $display("FAIL fetch_ack_cycle got %0d exp %0d", iack_i, exp_cyc); end
    n_checks++; if (if_instr !== exp_instr) begin n_fail++; $display("FAIL fetch_instr got %h exp %h", if_instr, exp_instr); end
    n_checks++; if (log_n - base !== 2 || log_a[base[7:0]] !== a0 || log_a[8'(base + 1)] !== a1) begin
      n_fail++; $display("FAIL fetch_order got n=%0d %h %h exp 2 %h %h", log_n - base, log_a[base[7:0]], log_a[8'(base + 1)], a0, a1);
    end
    idle(2);
  endtask

  task automatic test_conflict;
    int base, order, stall_bad;
    bit dm_done, if_done;
    base = log_n; order = 0; stall_bad = 0; dm_done = 0; if_done = 0; lat = 1;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010;
    if_req = 1'b1; if_addr = 32'h0000_0020;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (if_ack) begin
        if_done = 1; if_req = 1'b0;
        break;
      end
      if (!stall_if) stall_bad++;
      if (dm_ack) begin
        dm_done = 1; dm_req = 1'b0;
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    n_checks++; if (!(dm_done && if_done)) begin n_fail++; $display("FAIL conflict_done got dm=%0d if=%0d exp 1 1", dm_done, if_done); end
    n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL conflict_stall_if low cycles got %0d exp 0", stall_bad); end
    n_checks++; if (log_n - base !== 3 || log_a[base[7:0]] !== 16'h0010 || log_a[8'(base + 1)] !== 16'h0020 || log_a[8'(base + 2)] !== 16'h0021) begin
      n_fail++; $display("FAIL conflict_order got n=%0d %h %h %h exp 3 0010 0020 0021", log_n - base, log_a[base[7:0]], log_a[8'(base + 1)], log_a[8'(base + 2)]);
    end
    n_checks++; if (if_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL conflict_instr got %h exp 12345678", if_instr); end
    idle(2);
  endtask

  task automatic test_flush;
    int base, acks;
    base = log_n; acks = 0; lat = 2;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    @(negedge clk);
    @(negedge clk);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0; if_req = 1'b0;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_mem_req_held got %b exp 1", mem_req); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_ack) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL flush_if_ack got %0d exp 0", acks); end
    n_checks++; if (log_n - base !== 1 || log_a[base[7:0]] !== 16'h0040) begin n_fail++; $display("FAIL flush_txn got n=%0d a=%h exp 1 0040", log_n - base, log_a[base[7:0]]); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_mem_req got %b exp 0", mem_req); end
  endtask

  task automatic test_fairness;
    int dm_cnt, if_cnt;
    bit got_ack;
    dm_cnt = 0; if_cnt = 0; lat = 0;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010;
    if_req = 1'b1; if_addr = 32'h0000_0020;
`ifdef MEM_ARB_FAIR_EN
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dm_ack) dm_cnt++;
      if (if_ack) begin if_cnt++; break; end
    end
    dm_req = 1'b0; if_req = 1'b0;
    n_checks++; if (if_cnt !== 1) begin n_fail++; $display("FAIL fair_fetch_granted got %0d exp 1", if_cnt); end
    n_checks++; if (dm_cnt !== 4) begin n_fail++; $display("FAIL fair_dm_grants got %0d exp 4", dm_cnt); end
    n_checks++; if (if_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL fair_instr got %h exp 12345678", if_instr); end
`else
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dm_ack) dm_cnt++;
      if (if_ack) if_cnt++;
    end
    n_checks++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL strict_stall_if got %b exp 1", stall_if); end
    got_ack = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_ack) if_cnt++;
      if (dm_ack) begin dm_cnt++; got_ack = 1; break; end
    end
    dm_req = 1'b0; if_req = 1'b0;
    n_checks++; if (if_cnt !== 0) begin n_fail++; $display("FAIL strict_fetch_granted got %0d exp 0", if_cnt); end
    n_checks++; if (dm_cnt < 10 || !got_ack) begin n_fail++; $display("FAIL strict_dm_grants got %0d ack=%0d exp >=10 1", dm_cnt, got_ack); end
`endif
    idle(3);
  endtask

  task automatic test_reset_mid;
    lat = 5;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_data got %b exp 1", mem_req); end
    rst = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_req got %b exp 0", mem_req); end
    n_checks++; if (dm_ack !== 1'b0 || if_ack !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got %b%b%b exp 000", dm_ack, if_ack, mem_wr); end
    n_checks++; if (dm_rdata !== 16'h0 || if_instr !== 32'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_data got %h %h %h %h exp 0", dm_rdata, if_instr, mem_addr, mem_wdata);
    end
    @(negedge clk);
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask

  initial begin
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h1234;
    mem[16'h0021] = 16'h5678;
    mem[16'h0040] = 16'h1111;
    mem[16'h0041] = 16'h2222;
    mem[16'hFFFF] = 16'hCAFE;
    mem[16'h0000] = 16'hF00D;
    test_reset();
    test_data_read();
    test_data_write();
    test_fetch(32'h0000_0020, 16'h0020, 16'h0021, 32'h1234_5678, 5);
    test_conflict();
    test_flush();
    test_data_read();
    test_fetch(32'h0000_FFFF, 16'hFFFF, 16'h0000, 32'hCAFE_F00D, 5);
    test_fairness();
    test_reset_mid();
    test_data_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer sharing one single-port, 16-bit-wide memory between instruction fetch and the memory stage. Fetch needs two word reads per 32-bit instruction; the memory stage needs one read or write. The block runs the memory handshake, orders the transfers and returns completions, with stall indications toward the pipeline controller.

## Interface
- AW, 16: memory word-address width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  32  word address of the instruction's high half; low AW bits used.
- if_flush  in  1  jump taken; abandon the outstanding fetch.
- if_ack  out  1  one-cycle pulse; if_instr valid.
- if_instr  out  32  {mem[if_addr], mem[if_addr+1]}.
- dm_req  in  1  data request; level, held until dm_ack.
- dm_wr  in  1  1 = write, 0 = read; stable while dm_req is high.
- dm_addr  in  16  data word address.
- dm_wdata  in  16  write data.
- dm_ack  out  1  one-cycle pulse; dm_rdata valid on reads.
- dm_rdata  out  16  read data.
- stall_if, stall_dm  out  1 each  req & ~ack for that port; combinational.
- mem_req  out  1  memory request; held until mem_ack.
- mem_wr, mem_addr(AW), mem_wdata(16)  out  command fields; stable while mem_req is high.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  16  read data; valid with mem_ack.

## Operation
- States:
  - IDLE, DATA, FETCH_HI, FETCH_LO: one state per memory command.
  - RESP: one cycle, drives the ack.
- All outputs except stall_* and if_ack are registered.
- IDLE:
  - dm_req → DATA.
  - Otherwise if_req & ~if_flush → FETCH_HI.
  - Requests are sampled only in IDLE.
- DATA: on mem_ack, capture mem_rdata (reads) → RESP with dm_ack.
- FETCH_HI:
  - Address is if_addr.
  - On mem_ack, capture the high half → FETCH_LO.
  - FETCH_LO address = if_addr+1, modulo 2^AW; on wrap, address is 0.
- FETCH_LO: on mem_ack, capture the low half → RESP with if_ack.
- RESP → IDLE.
- if_flush during FETCH_HI or FETCH_LO:
  - A set "kill" bit records the flush.
  - The bus transaction already in flight completes; the memory command is never aborted.
  - Then → IDLE with no if_ack, and FETCH_LO is skipped.
  - kill clears in IDLE.
- if_ack = resp_if & ~if_flush & ~kill.
- dm_ack is never suppressed.
- The if_addr value is latched on leaving IDLE.
- Reset:
  - State returns to IDLE.
  - if_ack, dm_ack, mem_req and mem_wr reset to 0.
  - if_instr, dm_rdata, mem_addr and mem_wdata reset to 0.
  - kill and the starve counter reset to 0.
- Reset mid-transaction drops mem_req immediately. The memory must tolerate an abandoned request.

## Timing
- Request sampled in IDLE at edge k: mem_req is high from cycle k+1.
- mem_ack at cycle m: the ack is high in cycle m+1 (RESP).
- The arbiter is in IDLE in cycle m+2.
- Requesters must see the ack and deassert or change req by the end of cycle m+1.
- Best-case latency with mem_ack in the same cycle as mem_req:
  - data: 2 cycles from request to ack;
  - fetch: 3 cycles.
- There is one idle cycle between back-to-back transactions (RESP or IDLE). Maximum throughput is one data access per 3 cycles.
- Simultaneous if_req and dm_req in IDLE: data wins. The fetch waits with stall_if high.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A saturating counter counts data grants issued while if_req was pending.
  - When the counter reaches ARB_STARVE_MAX, the next IDLE grant goes to fetch even if dm_req is high.
  - The counter clears on each fetch grant.
- MEM_ARB_FAIR_EN undefined: strict data priority, and no counter exists.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, DATA, FETCH_HI, FETCH_LO, RESP);
  - ARB_STARVE_MAX = 4;
  - the counter width of 3.
- Sub-module mem_arb_starve holds the fairness counter. It is instantiated only under MEM_ARB_FAIR_EN.

## Test plan
- Data read: dm_req, dm_wr=0, dm_addr=0x0010, memory returns 0xBEEF after 2 cycles → one mem transaction at 0x0010, dm_ack 1 cycle after mem_ack, dm_rdata=0xBEEF.
- Fetch: if_addr=0x20, mem holds 0x1234 at 0x20 and 0x5678 at 0x21 → two reads, in order 0x20 then 0x21, then if_ack with if_instr=0x12345678.
- Conflict: if_req and dm_req rise in the same cycle → data transaction first, stall_if high throughout, then fetch completes.
- Flush: if_flush pulsed during FETCH_HI → mem_ack is honoured, no access at if_addr+1, no if_ack, arbiter in IDLE afterwards.
- Wrap and reset:
  - AW=16, if_addr=0xFFFF → second read at 0x0000.
  - rst asserted mid-DATA → mem_req=0 immediately, all outputs 0.
- Fairness (MEM_ARB_FAIR_EN): dm_req held high continuously with if_req pending → fetch granted after exactly 4 data grants. Without the macro, fetch is never granted.
